// File: rtl/core_pkg.sv
// core_pkg: shared types for the memory arbiter (response-tracker states, port identifiers)
package core_pkg;
    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_DM} arb_state_t;
    typedef enum logic {PORT_IF, PORT_DM} arb_port_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way grant (req_if/req_dm + prio in, one-hot gnt_if/gnt_dm out); lone requester always wins, prio breaks ties
module arb_rr2
    import core_pkg::*;
(
    input  logic      req_if,
    input  logic      req_dm,
    input  arb_port_t prio,
    output logic      gnt_if,
    output logic      gnt_dm
);
    assign gnt_dm = req_dm && (!req_if || prio == PORT_DM);
    assign gnt_if = req_if && !gnt_dm;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port sync memory between fetch (if_*) and data (dm_*) ports; combinational grant, 1-cycle response via tracker (mem_* is the memory side)
module mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    output logic                    dm_gnt_o,
    output logic                    dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    arb_state_t state;
    arb_port_t  prio;
    logic       st_flag;
    arb_rr2 u_arb (
        .req_if (if_req_i && rstn_i),
        .req_dm (dm_req_i && rstn_i),
        .prio   (prio),
        .gnt_if (if_gnt_o),
        .gnt_dm (dm_gnt_o)
    );
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            prio    <= PORT_DM;
            st_flag <= 1'b0;
        end else begin
            state   <= if_gnt_o ? RESP_IF : dm_gnt_o ? RESP_DM : IDLE;
            prio    <= if_gnt_o ? PORT_DM : dm_gnt_o ? PORT_IF : prio;
            if (dm_gnt_o) st_flag <= dm_we_i;
        end
    end
    assign mem_req_o   = if_gnt_o || dm_gnt_o;
    assign mem_we_o    = dm_gnt_o && dm_we_i;
    assign mem_be_o    = dm_gnt_o ? dm_be_i : if_gnt_o ? '1 : '0;
    assign mem_addr_o  = dm_gnt_o ? dm_addr_i : if_gnt_o ? if_addr_i : '0;
    assign mem_wdata_o = dm_gnt_o ? dm_wdata_i : '0;
    assign if_rvalid_o = state == RESP_IF;
    assign dm_rvalid_o = state == RESP_DM;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = (dm_rvalid_o && !st_flag) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of mem_arbiter against a behavioural single-port memory
module tb_mem_arbiter;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:63];

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
        mem_rdata_i = 32'h0;
    end

    always @(posedge clk_i) begin
        if (mem_req_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end else if (mem_req_o) begin
            mem_rdata_i <= mem[mem_addr_o[7:2]];
        end
    end

    typedef struct {
        logic ir; logic [31:0] ia;
        logic dr, dw; logic [3:0] db; logic [31:0] da, dd;
        logic gi, gd, we; logic [3:0] be; logic [31:0] addr, wd;
        logic iv; logic [31:0] ird;
        logic dv; logic [31:0] drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [3:0] db,
                                logic [31:0] da, logic [31:0] dd, logic gi, logic gd, logic we,
                                logic [3:0] be, logic [31:0] addr, logic [31:0] wd,
                                logic iv, logic [31:0] ird, logic dv, logic [31:0] drd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.db = db; v.da = da; v.dd = dd;
        v.gi = gi; v.gd = gd; v.we = we; v.be = be; v.addr = addr; v.wd = wd;
        v.iv = iv; v.ird = ird; v.dv = dv; v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
        if_req_i = ir; if_addr_i = ia; dm_req_i = dr; dm_we_i = dw;
        dm_be_i = db; dm_addr_i = da; dm_wdata_i = dd;
    endtask

    initial begin
        vecs.push_back(mk(0,32'h0, 1,0,4'hF,32'h40,32'h0, 0,1,0,4'hF,32'h40,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,32'h0, 0,0,4'h0,32'h0,32'h0,  0,0,0,4'h0,32'h0,32'h0,  0,32'h0, 1,32'hC0DE0010));
        vecs.push_back(mk(1,32'h8, 0,0,4'h0,32'h0,32'h0,  1,0,0,4'hF,32'h8,32'h0,  0,32'h0, 0,32'h0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1,32'h4, 1,0,4'hF,32'h40,32'h0, 0,1,0,4'hF,32'h40,32'h0,
                              1, k == 0 ? 32'hC0DE0002 : 32'hC0DE0001, 0,32'h0));
            vecs.push_back(mk(1,32'h4, 1,0,4'hF,32'h40,32'h0, 1,0,0,4'hF,32'h4,32'h0,
                              0,32'h0, 1,32'hC0DE0010));
        end
        vecs.push_back(mk(0,32'h0, 1,1,4'h3,32'h10,32'hDEADBEEF, 0,1,1,4'h3,32'h10,32'hDEADBEEF, 1,32'hC0DE0001, 0,32'h0));
        vecs.push_back(mk(0,32'h0, 1,0,4'hF,32'h10,32'h0, 0,1,0,4'hF,32'h10,32'h0, 0,32'h0, 1,32'h0));
        vecs.push_back(mk(0,32'h0, 0,0,4'h0,32'h0,32'h0,  0,0,0,4'h0,32'h0,32'h0,  0,32'h0, 1,32'hC0DEBEEF));
        vecs.push_back(mk(1,32'h0, 0,0,4'h0,32'h0,32'h0,  1,0,0,4'hF,32'h0,32'h0,  0,32'h0, 0,32'h0));
        vecs.push_back(mk(1,32'h4, 0,0,4'h0,32'h0,32'h0,  1,0,0,4'hF,32'h4,32'h0,  1,32'hC0DE0000, 0,32'h0));
        vecs.push_back(mk(1,32'h8, 0,0,4'h0,32'h0,32'h0,  1,0,0,4'hF,32'h8,32'h0,  1,32'hC0DE0001, 0,32'h0));
        vecs.push_back(mk(0,32'h0, 0,0,4'h0,32'h0,32'h0,  0,0,0,4'h0,32'h0,32'h0,  1,32'hC0DE0002, 0,32'h0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,32'h0, 0,0,4'h0,32'h0,32'h0, 0,0,0,4'h0,32'h0,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(1,32'h0, 1,0,4'hF,32'h40,32'h0, 0,1,0,4'hF,32'h40,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,32'h0, 0,0,4'h0,32'h0,32'h0,  0,0,0,4'h0,32'h0,32'h0,  0,32'h0, 1,32'hC0DE0010));

        rstn_i = 1'b0;
        drive(1, 32'h4, 1, 1, 4'hF, 32'h40, 32'h55);
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_if_gnt", {31'h0, if_gnt_o}, 32'h0);
        chk("rst_dm_gnt", {31'h0, dm_gnt_o}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_if_rvalid", {31'h0, if_rvalid_o}, 32'h0);
        chk("rst_dm_rvalid", {31'h0, dm_rvalid_o}, 32'h0);
        chk("rst_dm_rdata", dm_rdata_o, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].db, vecs[i].da, vecs[i].dd);
            #1;
            chk($sformatf("v%0d_if_gnt", i), {31'h0, if_gnt_o}, {31'h0, vecs[i].gi});
            chk($sformatf("v%0d_dm_gnt", i), {31'h0, dm_gnt_o}, {31'h0, vecs[i].gd});
            chk($sformatf("v%0d_mem_req", i), {31'h0, mem_req_o}, {31'h0, vecs[i].gi | vecs[i].gd});
            chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we_o}, {31'h0, vecs[i].we});
            chk($sformatf("v%0d_mem_be", i), {28'h0, mem_be_o}, {28'h0, vecs[i].be});
            chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].wd);
            chk($sformatf("v%0d_if_rvalid", i), {31'h0, if_rvalid_o}, {31'h0, vecs[i].iv});
            chk($sformatf("v%0d_if_rdata", i), if_rdata_o, vecs[i].ird);
            chk($sformatf("v%0d_dm_rvalid", i), {31'h0, dm_rvalid_o}, {31'h0, vecs[i].dv});
            chk($sformatf("v%0d_dm_rdata", i), dm_rdata_o, vecs[i].drd);
            @(negedge clk_i);
        end

        drive(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("pend_if_gnt", {31'h0, if_gnt_o}, 32'h1);
        @(negedge clk_i);
        rstn_i = 1'b0;
        drive(1, 32'h8, 1, 0, 4'hF, 32'h40, 32'h0);
        #1;
        chk("pend_rst_if_rvalid", {31'h0, if_rvalid_o}, 32'h0);
        chk("pend_rst_if_rdata", if_rdata_o, 32'h0);
        chk("pend_rst_gnt", {30'h0, if_gnt_o, dm_gnt_o}, 32'h0);
        chk("pend_rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        @(negedge clk_i);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        rstn_i = 1'b1;
        #1;
        chk("pend_rel_if_rvalid0", {31'h0, if_rvalid_o}, 32'h0);
        @(negedge clk_i);
        #1;
        chk("pend_rel_if_rvalid1", {31'h0, if_rvalid_o}, 32'h0);
        chk("pend_rel_dm_rvalid1", {31'h0, dm_rvalid_o}, 32'h0);
        @(negedge clk_i);

        drive(0, 32'h0, 1, 0, 4'hF, 32'h40, 32'h0);
        #1;
        chk("prio_dm_gnt", {31'h0, dm_gnt_o}, 32'h1);
        @(negedge clk_i);
        rstn_i = 1'b0;
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("prio_rst_dm_rvalid", {31'h0, dm_rvalid_o}, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        drive(1, 32'h0, 1, 0, 4'hF, 32'h40, 32'h0);
        #1;
        chk("prio_rel_dm_gnt", {31'h0, dm_gnt_o}, 32'h1);
        chk("prio_rel_if_gnt", {31'h0, if_gnt_o}, 32'h0);
        @(negedge clk_i);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("prio_rel_dm_rvalid", {31'h0, dm_rvalid_o}, 32'h1);
        chk("prio_rel_dm_rdata", dm_rdata_o, 32'hC0DE0010);
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
